// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: shared sck/cs_n SPI reader for N_CH simultaneously-sampled serial ADCs.
// sck is a registered divided clock. The block runs single-shot (trig) or continuous frames.
// Optional per-channel averaging is enabled by defining ADC_SAMPLER_AVG_EN.
module adc_spi_sampler #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned LEAD_BITS   = 2,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CS_HIGH_CYC = 4,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic                      clk_100,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      trig,
  output logic                      sck,
  output logic                      cs_n,
  input  logic [N_CH-1:0]           sdo,
  output logic [N_CH*DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned QuietW = $clog2(CS_HIGH_CYC + 1);
  localparam int unsigned DivW   = $clog2(CLK_DIV + 1);
  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
  localparam int unsigned MsbIdx = FRAME_BITS - 1 - LEAD_BITS;

  localparam logic [QuietW-1:0] QuietLast = QuietW'(CS_HIGH_CYC - 1);
  localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]   BitLast   = BitW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StQuiet, StShift, StDone} state_e;

  state_e                  state_q, state_d;
  logic [QuietW-1:0]       quiet_cnt_q, quiet_cnt_d;
  logic [DivW-1:0]         div_cnt_q, div_cnt_d;
  logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                    sck_q, sck_d;
  logic                    sck_rise;
  logic                    frame_done;

  logic [N_CH-1:0][FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [N_CH-1:0][DATA_BITS-1:0]  result;
  logic [N_CH*DATA_BITS-1:0]       data_q, data_d;
  logic                            valid_q, valid_d;
  logic                            overrun_q, overrun_d;

  // Frame sequencer: next state, sck divider and bit counter; enable=0 forces idle
  always_comb begin
    state_d     = state_q;
    quiet_cnt_d = quiet_cnt_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sck_d       = sck_q;
    sck_rise    = 1'b0;
    frame_done  = 1'b0;
    if (!enable) begin
      state_d     = StIdle;
      quiet_cnt_d = '0;
      div_cnt_d   = '0;
      bit_cnt_d   = '0;
      sck_d       = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mode || trig) begin
            state_d     = StQuiet;
            quiet_cnt_d = '0;
          end
        end
        StQuiet: begin
          if (quiet_cnt_q == QuietLast) begin
            state_d     = StShift;
            quiet_cnt_d = '0;
            div_cnt_d   = '0;
            bit_cnt_d   = '0;
            sck_d       = 1'b0;
          end else begin
            quiet_cnt_d = quiet_cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_d = '0;
            sck_d     = ~sck_q;
            if (!sck_q) begin
              sck_rise = 1'b1;
            end else if (bit_cnt_q == BitLast) begin
              // Falling edge after the last pulse ends the frame; cs_n rises on this edge
              state_d   = StDone;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        StDone: begin
          frame_done = 1'b1;
          state_d    = mode ? StQuiet : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      quiet_cnt_q <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sck_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quiet_cnt_q <= quiet_cnt_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sck_q       <= sck_d;
    end
  end

  // Per-channel MSB-first capture on each sck rising edge; aborts discard partial frames
  always_comb begin
    shreg_d = shreg_q;
    if (!enable) begin
      shreg_d = '0;
    end else if (sck_rise) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        shreg_d[k] = {shreg_q[k][FRAME_BITS-2:0], sdo[k]};
      end
    end
  end

  // Result field of each channel after dropping the leading bits
  always_comb begin
    for (int k = 0; k < int'(N_CH); k++) begin
      result[k] = shreg_q[k][MsbIdx -: DATA_BITS];
    end
  end

  // The MSB only ever holds a discarded leading bit
  logic [N_CH-1:0] unused_shreg_msb;
  always_comb begin
    for (int k = 0; k < int'(N_CH); k++) begin
      unused_shreg_msb[k] = shreg_q[k][FRAME_BITS-1];
    end
  end

`ifdef ADC_SAMPLER_AVG_EN
  localparam int unsigned AccW    = DATA_BITS + AVG_LOG2;
  localparam int unsigned AvgCntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [AvgCntW-1:0] AvgLast = AvgCntW'((1 << AVG_LOG2) - 1);

  logic [N_CH-1:0][AccW-1:0] acc_q, acc_d, acc_sum;
  logic [AvgCntW-1:0]        avg_cnt_q, avg_cnt_d;

  // Accumulate 2^AVG_LOG2 frames, then publish the truncated mean and restart
  always_comb begin
    data_d    = data_q;
    valid_d   = 1'b0;
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    for (int k = 0; k < int'(N_CH); k++) begin
      acc_sum[k] = acc_q[k] + AccW'(result[k]);
    end
    if (!enable) begin
      acc_d     = '0;
      avg_cnt_d = '0;
    end else if (frame_done) begin
      if (avg_cnt_q == AvgLast) begin
        valid_d   = 1'b1;
        acc_d     = '0;
        avg_cnt_d = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
          data_d[k*DATA_BITS +: DATA_BITS] = DATA_BITS'(acc_sum[k] >> AVG_LOG2);
        end
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + 1'b1;
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  // Every completed frame publishes its results directly
  always_comb begin
    data_d  = data_q;
    valid_d = frame_done;
    if (frame_done) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        data_d[k*DATA_BITS +: DATA_BITS] = result[k];
      end
    end
  end

  logic unused_avg;
  assign unused_avg = ^AVG_LOG2;
`endif

  // Sticky overrun: a single-shot trigger while a frame is in flight
  always_comb begin
    overrun_d = overrun_q;
    if (!enable) begin
      overrun_d = 1'b0;
    end else if (trig && !mode && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sck     = sck_q;
  assign cs_n    = (state_q != StShift);
  assign busy    = (state_q != StIdle);
  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: table vectors, randomized frames against a frame-level reference
// model, and hand-written sequences for continuous mode, overrun, abort and reset.
module tb_adc_spi_sampler;

  localparam int N_CH = 2;
  localparam int FB   = 16;
  localparam int DB   = 12;
  localparam int LB   = 2;
  localparam int CD   = 2;
  localparam int CSH  = 4;
  localparam int T    = CSH + 2 * CD * FB + 1;
`ifdef ADC_SAMPLER_AVG_EN
  localparam int AD = 4;
`else
  localparam int AD = 1;
`endif

  logic                 clk_100;
  logic                 reset_n;
  logic                 enable;
  logic                 mode;
  logic                 trig;
  logic                 sck;
  logic                 cs_n;
  logic [N_CH-1:0]      sdo;
  logic [N_CH*DB-1:0]   data;
  logic                 valid;
  logic                 busy;
  logic                 overrun;

  adc_spi_sampler #(
    .N_CH        (N_CH),
    .FRAME_BITS  (FB),
    .DATA_BITS   (DB),
    .LEAD_BITS   (LB),
    .CLK_DIV     (CD),
    .CS_HIGH_CYC (CSH),
    .AVG_LOG2    (2)
  ) dut (
    .clk_100 (clk_100),
    .reset_n (reset_n),
    .enable  (enable),
    .mode    (mode),
    .trig    (trig),
    .sck     (sck),
    .cs_n    (cs_n),
    .sdo     (sdo),
    .data    (data),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  initial begin
    clk_100 = 1'b0;
    forever #5 clk_100 = ~clk_100;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk_100) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference model: the ADC word of each frame, and the published results
  logic [FB-1:0]       w0_q[$];
  logic [FB-1:0]       w1_q[$];
  logic [N_CH*DB-1:0]  exp_q[$];
  logic [FB-1:0]       cur_w0 = '0;
  logic [FB-1:0]       cur_w1 = '0;
  int acc0 = 0, acc1 = 0, nfr = 0;
  logic [N_CH*DB-1:0]  last_exp = '0;

  function automatic int field(input logic [FB-1:0] w);
    return (int'(w) >> (FB - LB - DB)) & ((1 << DB) - 1);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    w0_q.delete();
    w1_q.delete();
    acc0 = 0;
    acc1 = 0;
    nfr  = 0;
  endtask

  // Bus monitor / ADC model: serves sdo bits, measures frames, scores valid
  logic cs_prev = 1'b1;
  logic sck_prev = 1'b0;
  int rise_cnt = 0, low_len = 0, hi_len = 0, last_low = 0, last_rises = 0;
  int sck_viol = 0, nvalid = 0, nframes = 0, vcyc = 0, last_vcyc = 0;
  bit chk_period = 0, have_frame = 0, have_valid = 0;
  logic busy_at_valid = 1'b0;
  int idx;

  always @(negedge clk_100) begin
    if (cs_prev && !cs_n) begin
      nframes++;
      if (chk_period && have_frame) check("cs_high_gap_min", hi_len >= CSH, 1);
      cur_w0 = (w0_q.size() > 0) ? w0_q.pop_front() : FB'($urandom);
      cur_w1 = (w1_q.size() > 0) ? w1_q.pop_front() : FB'($urandom);
      acc0 += field(cur_w0);
      acc1 += field(cur_w1);
      nfr++;
      if (nfr == AD) begin
        exp_q.push_back({DB'(acc1 / AD), DB'(acc0 / AD)});
        acc0 = 0;
        acc1 = 0;
        nfr  = 0;
      end
      rise_cnt = 0;
      low_len  = 0;
    end
    if (!cs_n) begin
      low_len++;
      if (sck && !sck_prev) rise_cnt++;
      hi_len = 0;
    end else begin
      hi_len++;
      if (sck) sck_viol++;
    end
    if (!cs_prev && cs_n) begin
      last_low   = low_len;
      last_rises = rise_cnt;
      have_frame = 1;
    end
    idx = (rise_cnt < FB) ? (FB - 1 - rise_cnt) : 0;
    sdo = {cur_w1[idx], cur_w0[idx]};
    if (valid) begin
      nvalid++;
      vcyc = cyc;
      busy_at_valid = busy;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL valid_expected: got valid with data 0x%0h, required no valid", data);
      end else begin
        last_exp = exp_q.pop_front();
        check("data_vs_model", data, last_exp);
      end
      if (chk_period && have_valid) check("valid_period", vcyc - last_vcyc, T * AD);
      last_vcyc  = vcyc;
      have_valid = 1;
    end
    cs_prev  = cs_n;
    sck_prev = sck;
  end

  int trig_cyc = 0;

  task automatic do_trig();
    @(negedge clk_100);
    trig = 1'b1;
    @(posedge clk_100);
    #1;
    trig_cyc = cyc;
    trig = 1'b0;
  endtask

  // Latency counts edges from the trig-sampling edge to the edge that captures valid
  task automatic wait_valid(output int lat);
    int s;
    s = nvalid;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_100);
      #2;
      if (nvalid != s) begin
        lat = vcyc - trig_cyc + 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      $display("FAIL valid_timeout: got no valid in 400 cycles, required one");
    end
  endtask

`ifndef ADC_SAMPLER_AVG_EN
  typedef struct {
    logic [FB-1:0]      w0;
    logic [FB-1:0]      w1;
    logic [N_CH*DB-1:0] exp;
  } vec_t;
  vec_t tbl[6];
`endif

  int lat, n0, f0;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 1'b0;
    trig    = 1'b0;
    repeat (3) @(posedge clk_100);
    #1;
    check("rst_sck", sck, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk_100);
    reset_n = 1'b1;
    enable  = 1'b1;

`ifndef ADC_SAMPLER_AVG_EN
    tbl[0] = '{w0: 16'h2AF0, w1: 16'h1554, exp: 24'h555ABC};
    tbl[1] = '{w0: 16'hFFFF, w1: 16'h0000, exp: 24'h000FFF};
    tbl[2] = '{w0: 16'hC003, w1: 16'h3FFC, exp: 24'hFFF000};
    tbl[3] = '{w0: 16'h8001, w1: 16'h4002, exp: 24'h000000};
    tbl[4] = '{w0: 16'h0004, w1: 16'h2000, exp: 24'h800001};
    tbl[5] = '{w0: 16'h5A5A, w1: 16'hA5A5, exp: 24'h969696};
    for (int i = 0; i < 6; i++) begin
      w0_q.push_back(tbl[i].w0);
      w1_q.push_back(tbl[i].w1);
      do_trig();
      check("busy_after_trig", busy, 1);
      wait_valid(lat);
      check("single_latency", lat, T + 1);
      check("table_data", data, tbl[i].exp);
      check("valid_one_cycle", valid, 0);
      check("cs_low_cycles", last_low, 2 * CD * FB);
      check("sck_rises", last_rises, FB);
      check("busy_fall_after_done", busy_at_valid, 0);
      repeat (3) @(posedge clk_100);
    end

    // Random single-shot frames scored by the monitor's model
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 10)) @(negedge clk_100);
      do_trig();
      wait_valid(lat);
      check("rand_latency", lat, T + 1);
    end
`endif

    // Continuous mode with ignored mode-1 triggers
    @(posedge clk_100);
    #1;
    clear_model();
    have_frame = 0;
    have_valid = 0;
    chk_period = 1;
    n0 = nvalid;
    @(negedge clk_100);
    mode = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk_100);
      trig = ((i % 37) == 0);
    end
    trig = 1'b0;
    check("mode1_trig_no_overrun", overrun, 0);
    enable = 1'b0;
    mode   = 1'b0;
    @(posedge clk_100);
    #1;
    chk_period = 0;
    check("cont_valid_count", nvalid - n0, 499 / (T * AD));
    check("cont_abort_idle", busy, 0);
    repeat (2) @(posedge clk_100);
    #1;
    clear_model();
    @(negedge clk_100);
    enable = 1'b1;

    // Overrun: second trigger 20 cycles into the frame
    n0 = nvalid;
    f0 = nframes;
    do_trig();
    repeat (19) @(posedge clk_100);
    @(negedge clk_100);
    trig = 1'b1;
    @(posedge clk_100);
    #1;
    trig = 1'b0;
    check("overrun_set", overrun, 1);
    repeat (150) @(posedge clk_100);
    #1;
    check("overrun_valids", nvalid - n0, (AD == 1) ? 1 : 0);
    check("overrun_frames", nframes - f0, 1);
    check("overrun_sticky", overrun, 1);
    check("overrun_idle", busy, 0);
    @(negedge clk_100);
    enable = 1'b0;
    @(posedge clk_100);
    #1;
    check("overrun_clear", overrun, 0);
    clear_model();
    @(negedge clk_100);
    enable = 1'b1;

    // Abort during SHIFT cycle 30
    do_trig();
    for (int i = 0; i < 20 && cs_n; i++) begin
      @(posedge clk_100);
      #1;
    end
    check("abort_in_shift", cs_n, 0);
    repeat (29) @(posedge clk_100);
    @(negedge clk_100);
    enable = 1'b0;
    @(posedge clk_100);
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    n0 = nvalid;
    repeat (100) @(posedge clk_100);
    #1;
    check("abort_no_valid", nvalid - n0, 0);
    check("abort_data_hold", data, last_exp);
    clear_model();
    @(negedge clk_100);
    enable = 1'b1;

    // Reset for one cycle mid-frame
    do_trig();
    repeat (16) @(posedge clk_100);
    @(negedge clk_100);
    reset_n = 1'b0;
    @(posedge clk_100);
    #1;
    check("midrst_sck", sck, 0);
    check("midrst_cs_n", cs_n, 1);
    check("midrst_data", data, 0);
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    clear_model();
    last_exp = '0;
    @(negedge clk_100);
    reset_n = 1'b1;

`ifdef ADC_SAMPLER_AVG_EN
    // Four continuous frames on ch0: 100, 101, 102, 104 average to 101
    w0_q.push_back(FB'(100 << LB));
    w0_q.push_back(FB'(101 << LB));
    w0_q.push_back(FB'(102 << LB));
    w0_q.push_back(FB'(104 << LB));
    n0 = nvalid;
    @(negedge clk_100);
    mode = 1'b1;
    @(posedge clk_100);
    #1;
    trig_cyc = cyc;
    wait_valid(lat);
    check("avg_ch0", data[DB-1:0], 101);
    check("avg_single_valid", nvalid - n0, 1);
    check("avg_latency", lat, 4 * T + 1);
    @(negedge clk_100);
    enable = 1'b0;
    mode   = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;
    clear_model();
`endif

    check("sck_low_when_cs_high", sck_viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
